rob_superscalar: RTL and testbench

- Parametrised multi-issue / multi-commit reorder buffer for the out-of-order core.
- Accepts up to ISSUE_WIDTH dispatched instructions per cycle and captures results from CDB_SIZE broadcast channels.
- Retires up to COMMIT_WIDTH ready entries per cycle in program order.
- Tracks branch mispredicts and raises a precise flush when a mispredicted branch retires.

---
 rtl/rob_superscalar.sv | 198 +++++++++++++++++++
 tb/tb_rob_superscalar.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_superscalar.sv
// Multi-issue, multi-commit reorder buffer with CDB writeback, operand
// bypass lookup and precise flush on retirement of a mispredicted branch.
module rob_superscalar #(
    parameter int ROB_DEPTH_BITS = 4,
    parameter int ISSUE_WIDTH    = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int CDB_SIZE       = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ext_flush,
    input  logic [ISSUE_WIDTH-1:0]                 disp_valid,
    input  logic [ISSUE_WIDTH*5-1:0]               disp_rd_s,
    input  logic [ISSUE_WIDTH-1:0]                 disp_is_branch,
    input  logic [ISSUE_WIDTH*32-1:0]              disp_pred_pc,
    output logic                                   disp_ready,
    output logic [ISSUE_WIDTH*ROB_DEPTH_BITS-1:0]  disp_rob,
    input  logic [2*ISSUE_WIDTH*ROB_DEPTH_BITS-1:0] src_rob,
    output logic [2*ISSUE_WIDTH-1:0]               src_ready,
    output logic [2*ISSUE_WIDTH*32-1:0]            src_v,
    input  logic [CDB_SIZE-1:0]                    cdb_valid,
    input  logic [CDB_SIZE*ROB_DEPTH_BITS-1:0]     cdb_rob,
    input  logic [CDB_SIZE*32-1:0]                 cdb_rd_v,
    input  logic                                   cdb_br_valid,
    input  logic [ROB_DEPTH_BITS-1:0]              cdb_br_rob,
    input  logic [31:0]                            cdb_br_target,
    input  logic                                   commit_stall,
    output logic [COMMIT_WIDTH-1:0]                commit_valid,
    output logic [COMMIT_WIDTH*5-1:0]              commit_rd_s,
    output logic [COMMIT_WIDTH*32-1:0]             commit_rd_v,
    output logic [COMMIT_WIDTH*ROB_DEPTH_BITS-1:0] commit_rob,
    output logic                                   flush,
    output logic [31:0]                            flush_pc,
    output logic [ROB_DEPTH_BITS:0]                count
);
    localparam int NUM_ENTRIES = 1 << ROB_DEPTH_BITS;
    typedef logic [ROB_DEPTH_BITS-1:0] idx_t;
    typedef logic [ROB_DEPTH_BITS:0]   cnt_t;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_ready;
    logic [NUM_ENTRIES-1:0] r_misp;
    logic [NUM_ENTRIES-1:0] r_isbr;
    logic [4:0]             r_rd      [NUM_ENTRIES];
    logic [31:0]            r_value   [NUM_ENTRIES];
    logic [31:0]            r_next_pc [NUM_ENTRIES];
    idx_t                   r_head;
    idx_t                   r_tail;
    cnt_t                   r_count;

    cnt_t w_free;
    cnt_t w_npush;
    cnt_t w_npop;
    logic w_br_hit;

    assign count = r_count;
    assign w_br_hit = cdb_br_valid && r_valid[cdb_br_rob] && r_isbr[cdb_br_rob]
                      && (cdb_br_target != r_next_pc[cdb_br_rob]);

    // Dispatch admission and per-lane slot allocation
    always_comb begin
        w_free     = cnt_t'(NUM_ENTRIES) - r_count;
        disp_ready = (w_free >= cnt_t'(ISSUE_WIDTH));
        w_npush    = '0;
        disp_rob   = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            disp_rob[i*ROB_DEPTH_BITS +: ROB_DEPTH_BITS] = r_tail + idx_t'(i);
            if (disp_ready && disp_valid[i]) begin
                w_npush = w_npush + cnt_t'(1);
            end else begin
                w_npush = w_npush;
            end
        end
    end

    // In-order retirement; a mispredicted entry ends the commit group and flushes
    always_comb begin
        logic v_stop;
        idx_t v_idx;
        v_stop       = 1'b0;
        v_idx        = '0;
        w_npop       = '0;
        commit_valid = '0;
        commit_rd_s  = '0;
        commit_rd_v  = '0;
        commit_rob   = '0;
        flush        = 1'b0;
        flush_pc     = 32'h0000_0000;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            v_idx = r_head + idx_t'(i);
            commit_rob[i*ROB_DEPTH_BITS +: ROB_DEPTH_BITS] = v_idx;
            commit_rd_s[i*5 +: 5]   = r_rd[v_idx];
            commit_rd_v[i*32 +: 32] = r_value[v_idx];
            if (!commit_stall && !v_stop && (r_count > cnt_t'(i)) && r_valid[v_idx] && r_ready[v_idx]) begin
                commit_valid[i] = 1'b1;
                w_npop = w_npop + cnt_t'(1);
                if (r_misp[v_idx]) begin
                    flush    = 1'b1;
                    flush_pc = r_next_pc[v_idx];
                    v_stop   = 1'b1;
                end else begin
                    v_stop = v_stop;
                end
            end else begin
                v_stop = 1'b1;
            end
        end
    end

    // Operand lookup with same-cycle CDB bypass (highest channel wins)
    always_comb begin
        idx_t v_tag;
        logic v_hit;
        v_tag     = '0;
        v_hit     = 1'b0;
        src_ready = '0;
        src_v     = '0;
        for (int j = 0; j < 2*ISSUE_WIDTH; j++) begin
            v_tag = src_rob[j*ROB_DEPTH_BITS +: ROB_DEPTH_BITS];
            v_hit = 1'b0;
            src_v[j*32 +: 32] = r_value[v_tag];
            for (int k = 0; k < CDB_SIZE; k++) begin
                if (cdb_valid[k] && (cdb_rob[k*ROB_DEPTH_BITS +: ROB_DEPTH_BITS] == v_tag)) begin
                    v_hit = 1'b1;
                    src_v[j*32 +: 32] = cdb_rd_v[k*32 +: 32];
                end else begin
                    v_hit = v_hit;
                end
            end
            src_ready[j] = r_valid[v_tag] && (r_ready[v_tag] || v_hit);
        end
    end

    // Control state: pointers, occupancy and per-entry status bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_ready <= '0;
            r_misp  <= '0;
        end else if (ext_flush || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_ready <= '0;
            r_misp  <= '0;
        end else begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (disp_ready && disp_valid[i]) begin
                    r_valid[r_tail + idx_t'(i)] <= 1'b1;
                    r_ready[r_tail + idx_t'(i)] <= 1'b0;
                    r_misp[r_tail + idx_t'(i)]  <= 1'b0;
                end
            end
            for (int k = 0; k < CDB_SIZE; k++) begin
                if (cdb_valid[k] && r_valid[cdb_rob[k*ROB_DEPTH_BITS +: ROB_DEPTH_BITS]]) begin
                    r_ready[cdb_rob[k*ROB_DEPTH_BITS +: ROB_DEPTH_BITS]] <= 1'b1;
                end
            end
            if (w_br_hit) begin
                r_misp[cdb_br_rob] <= 1'b1;
            end
            // Retirement clears last so same-cycle CDB writes to popped slots are dropped
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_valid[i]) begin
                    r_valid[r_head + idx_t'(i)] <= 1'b0;
                    r_ready[r_head + idx_t'(i)] <= 1'b0;
                    r_misp[r_head + idx_t'(i)]  <= 1'b0;
                end
            end
            r_head  <= r_head + idx_t'(w_npop);
            r_tail  <= r_tail + idx_t'(w_npush);
            r_count <= r_count + w_npush - w_npop;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (disp_ready && disp_valid[i]) begin
                r_rd[r_tail + idx_t'(i)]      <= disp_rd_s[i*5 +: 5];
                r_isbr[r_tail + idx_t'(i)]    <= disp_is_branch[i];
                r_next_pc[r_tail + idx_t'(i)] <= disp_pred_pc[i*32 +: 32];
            end
        end
        for (int k = 0; k < CDB_SIZE; k++) begin
            if (cdb_valid[k] && r_valid[cdb_rob[k*ROB_DEPTH_BITS +: ROB_DEPTH_BITS]]) begin
                r_value[cdb_rob[k*ROB_DEPTH_BITS +: ROB_DEPTH_BITS]] <= cdb_rd_v[k*32 +: 32];
            end
        end
        if (w_br_hit) begin
            r_next_pc[cdb_br_rob] <= cdb_br_target;
        end
    end
endmodule

// File: tb/tb_rob_superscalar.sv
// Directed-vector bench for rob_superscalar with hand-computed expectations.
module tb_rob_superscalar;
    logic        clk;
    logic        rst;
    logic        ext_flush;
    logic [1:0]  disp_valid;
    logic [9:0]  disp_rd_s;
    logic [1:0]  disp_is_branch;
    logic [63:0] disp_pred_pc;
    logic        disp_ready;
    logic [7:0]  disp_rob;
    logic [15:0] src_rob;
    logic [3:0]  src_ready;
    logic [127:0] src_v;
    logic [3:0]  cdb_valid;
    logic [15:0] cdb_rob;
    logic [127:0] cdb_rd_v;
    logic        cdb_br_valid;
    logic [3:0]  cdb_br_rob;
    logic [31:0] cdb_br_target;
    logic        commit_stall;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd_s;
    logic [63:0] commit_rd_v;
    logic [7:0]  commit_rob;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    rob_superscalar dut (
        .clk(clk), .rst(rst), .ext_flush(ext_flush),
        .disp_valid(disp_valid), .disp_rd_s(disp_rd_s), .disp_is_branch(disp_is_branch),
        .disp_pred_pc(disp_pred_pc), .disp_ready(disp_ready), .disp_rob(disp_rob),
        .src_rob(src_rob), .src_ready(src_ready), .src_v(src_v),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
        .cdb_br_valid(cdb_br_valid), .cdb_br_rob(cdb_br_rob), .cdb_br_target(cdb_br_target),
        .commit_stall(commit_stall), .commit_valid(commit_valid), .commit_rd_s(commit_rd_s),
        .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ext_flush = 1'b0; disp_valid = 2'b00; disp_rd_s = 10'd0; disp_is_branch = 2'b00;
        disp_pred_pc = 64'd0; src_rob = 16'd0; cdb_valid = 4'd0; cdb_rob = 16'd0;
        cdb_rd_v = 128'd0; cdb_br_valid = 1'b0; cdb_br_rob = 4'd0; cdb_br_target = 32'd0;
        commit_stall = 1'b0;
    endtask

    task automatic disp2(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [1:0] br, input logic [31:0] pc0, input logic [31:0] pc1);
        disp_valid = v; disp_rd_s = {rd1, rd0}; disp_is_branch = br; disp_pred_pc = {pc1, pc0};
    endtask

    task automatic cdb_set(input int k, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[k] = 1'b1;
        cdb_rob[k*4 +: 4] = tag;
        cdb_rd_v[k*32 +: 32] = val;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        step(); step();
        n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL reset_commit_valid: got %b want 00", commit_valid); end
        n_cmp++; if (flush !== 1'b0 || flush_pc !== 32'd0) begin n_bad++; $display("FAIL reset_flush: got %b/%h want 0/0", flush, flush_pc); end
        n_cmp++; if (count !== 5'd0 || src_ready !== 4'd0) begin n_bad++; $display("FAIL reset_count_src: got %0d/%b want 0/0000", count, src_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_dispatch;
        disp2(2'b11, 5'd5, 5'd6, 2'b00, 32'd0, 32'd0);
        #1;
        n_cmp++; if (disp_rob !== 8'h10) begin n_bad++; $display("FAIL disp_rob_first: got %h want 10", disp_rob); end
        step(); clear_inputs(); #1;
        n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL disp_count: got %0d want 2", count); end
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL disp_no_commit: got %b want 00", commit_valid); end
    endtask

    task automatic test_cdb_commit;
        cdb_set(0, 4'd1, 32'hAA); #1;
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL cdb_wait_a: got %b want 00", commit_valid); end
        step(); clear_inputs();
        cdb_set(0, 4'd0, 32'h55); #1;
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL cdb_wait_b: got %b want 00", commit_valid); end
        step(); clear_inputs(); #1;
        n_cmp++; if (commit_valid !== 2'b11) begin n_bad++; $display("FAIL cdb_commit_valid: got %b want 11", commit_valid); end
        n_cmp++; if (commit_rd_v !== {32'hAA, 32'h55}) begin n_bad++; $display("FAIL cdb_commit_v: got %h want aa/55", commit_rd_v); end
        n_cmp++; if (commit_rd_s !== {5'd6, 5'd5} || commit_rob !== 8'h10) begin n_bad++; $display("FAIL cdb_commit_tags: got %h/%h want 0c5/10", commit_rd_s, commit_rob); end
        step(); #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL cdb_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_full_wrap;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            disp2(2'b11, 5'(c), 5'(c + 8), 2'b00, 32'd0, 32'd0);
            #1;
            if (c == 0) begin
                n_cmp++; if (disp_rob !== 8'h32) begin n_bad++; $display("FAIL fill_rob_first: got %h want 32", disp_rob); end
            end
            if (c == 7) begin
                n_cmp++; if (disp_rob !== 8'h10) begin n_bad++; $display("FAIL fill_rob_wrap: got %h want 10", disp_rob); end
            end
            step();
        end
        clear_inputs(); #1;
        n_cmp++; if (count !== 5'd16 || disp_ready !== 1'b0) begin n_bad++; $display("FAIL full_state: got %0d/%b want 16/0", count, disp_ready); end
        disp2(2'b11, 5'd1, 5'd2, 2'b00, 32'd0, 32'd0);
        step(); clear_inputs(); #1;
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_ignore: got %0d want 16", count); end
        cdb_set(0, 4'd2, 32'h11);
        step(); clear_inputs(); #1;
        n_cmp++; if (commit_valid !== 2'b01 || commit_rob[3:0] !== 4'd2) begin n_bad++; $display("FAIL commit_one: got %b/%h want 01/2", commit_valid, commit_rob); end
        step(); #1;
        n_cmp++; if (count !== 5'd15 || disp_ready !== 1'b0) begin n_bad++; $display("FAIL free_one: got %0d/%b want 15/0", count, disp_ready); end
        cdb_set(0, 4'd3, 32'h33); cdb_set(1, 4'd4, 32'h44);
        step(); clear_inputs();
        commit_stall = 1'b1; #1;
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL stall: got %b want 00", commit_valid); end
        step(); commit_stall = 1'b0; #1;
        n_cmp++; if (commit_valid !== 2'b11 || commit_rd_v !== {32'h44, 32'h33}) begin n_bad++; $display("FAIL commit_two: got %b/%h want 11/44,33", commit_valid, commit_rd_v); end
        step(); #1;
        n_cmp++; if (count !== 5'd13 || disp_ready !== 1'b1) begin n_bad++; $display("FAIL free_three: got %0d/%b want 13/1", count, disp_ready); end
        ext_flush = 1'b1;
        step(); clear_inputs(); #1;
        n_cmp++; if (count !== 5'd0 || disp_ready !== 1'b1) begin n_bad++; $display("FAIL ext_flush: got %0d/%b want 0/1", count, disp_ready); end
    endtask

    task automatic test_branch_flush;
        disp2(2'b11, 5'd1, 5'd2, 2'b00, 32'd0, 32'd0); #1;
        n_cmp++; if (disp_rob !== 8'h10) begin n_bad++; $display("FAIL flush_ptr_reset: got %h want 10", disp_rob); end
        step();
        disp2(2'b11, 5'd3, 5'd4, 2'b10, 32'd0, 32'h100);
        step();
        disp2(2'b01, 5'd7, 5'd0, 2'b00, 32'd0, 32'd0);
        step(); clear_inputs();
        cdb_set(0, 4'd0, 32'h10); cdb_set(1, 4'd1, 32'h11); cdb_set(2, 4'd2, 32'h12);
        cdb_br_valid = 1'b1; cdb_br_rob = 4'd3; cdb_br_target = 32'h200;
        step(); clear_inputs(); #1;
        n_cmp++; if (commit_valid !== 2'b11 || commit_rob !== 8'h10) begin n_bad++; $display("FAIL br_pre_commit: got %b/%h want 11/10", commit_valid, commit_rob); end
        step(); #1;
        n_cmp++; if (commit_valid !== 2'b01 || flush !== 1'b0) begin n_bad++; $display("FAIL br_tag2: got %b/%b want 01/0", commit_valid, flush); end
        step();
        cdb_set(0, 4'd3, 32'h13); cdb_set(1, 4'd4, 32'h14); #1;
        n_cmp++; if (commit_valid !== 2'b00) begin n_bad++; $display("FAIL br_wait: got %b want 00", commit_valid); end
        step(); clear_inputs(); #1;
        n_cmp++; if (commit_valid !== 2'b01 || commit_rob[3:0] !== 4'd3) begin n_bad++; $display("FAIL br_commit: got %b/%h want 01/3", commit_valid, commit_rob); end
        n_cmp++; if (flush !== 1'b1 || flush_pc !== 32'h200) begin n_bad++; $display("FAIL br_flush: got %b/%h want 1/200", flush, flush_pc); end
        step(); #1;
        n_cmp++; if (count !== 5'd0 || flush !== 1'b0) begin n_bad++; $display("FAIL br_after: got %0d/%b want 0/0", count, flush); end
    endtask

    task automatic test_src_bypass;
        for (int c = 0; c < 4; c++) begin
            disp2(2'b11, 5'(c), 5'(c + 4), 2'b00, 32'd0, 32'd0);
            step();
        end
        clear_inputs();
        src_rob[3:0] = 4'd7; src_rob[7:4] = 4'd9;
        cdb_set(2, 4'd7, 32'h1234); #1;
        n_cmp++; if (src_ready[1:0] !== 2'b01) begin n_bad++; $display("FAIL src_ready_bypass: got %b want 01", src_ready[1:0]); end
        n_cmp++; if (src_v[31:0] !== 32'h1234) begin n_bad++; $display("FAIL src_v_bypass: got %h want 1234", src_v[31:0]); end
        step(); clear_inputs();
        src_rob[11:8] = 4'd7; #1;
        n_cmp++; if (src_ready[2] !== 1'b1 || src_v[95:64] !== 32'h1234) begin n_bad++; $display("FAIL src_stored: got %b/%h want 1/1234", src_ready[2], src_v[95:64]); end
    endtask

    task automatic test_async_reset;
        disp2(2'b01, 5'd9, 5'd0, 2'b00, 32'd0, 32'd0);
        step(); clear_inputs();
        src_rob[11:8] = 4'd7; #1;
        n_cmp++; if (count !== 5'd9 || src_ready[2] !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got %0d/%b want 9/1", count, src_ready[2]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (count !== 5'd0 || disp_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_count: got %0d/%b want 0/1", count, disp_ready); end
        n_cmp++; if (src_ready !== 4'd0 || commit_valid !== 2'b00 || flush !== 1'b0) begin n_bad++; $display("FAIL async_rst_outs: got %b/%b/%b want 0000/00/0", src_ready, commit_valid, flush); end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_cdb_commit();
        test_full_wrap();
        test_branch_flush();
        test_src_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
